// File: rtl/vmem_arb_pkg.sv
// Shared types and constants for the video-memory arbiter and its write buffer.
package vmem_arb_pkg;

  localparam int ARB_H_W        = 10;
  localparam int ARB_V_W        = 9;
  localparam int ARB_DATA_W     = 24;
  localparam int ARB_FIFO_DEPTH = 4;
  localparam int STALL_CNT_W    = 16;

  typedef enum logic [1:0] {
    IDLE,
    PEND,
    WRITE
  } arb_state_e;

  typedef struct packed {
    logic [ARB_H_W-1:0]    h;
    logic [ARB_V_W-1:0]    v;
    logic [ARB_DATA_W-1:0] data;
  } wr_entry_t;

endpackage

// File: rtl/vmem_wr_fifo.sv
// Small synchronous write buffer for the arbiter.
// Supports push, pop and flush. A push is also taken while full if a pop happens in the same cycle.
// Pointers wrap naturally because DEPTH is a power of two.
module vmem_wr_fifo #(
  parameter  int WIDTH = 43,
  parameter  int DEPTH = 4,
  localparam int AW    = $clog2(DEPTH),
  localparam int LW    = AW + 1
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             push,
  input  logic             pop,
  input  logic             flush,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty,
  output logic [LW-1:0]    level
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign full    = (level == LW'(DEPTH));
  assign empty   = (level == '0);
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign dout    = mem[rd_ptr];

  // Pointer and occupancy bookkeeping; flush returns to the empty state.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      level <= level + LW'(do_push) - LW'(do_pop);
    end
  end

  // Storage array; contents need no reset because occupancy tracks validity.
  always_ff @(posedge clk) begin
    if (do_push && !flush) mem[wr_ptr] <= din;
  end

endmodule

// File: rtl/vmem_arbiter.sv
// Video-memory port arbiter.
// Display reads always own the port. Buffered pixel writes drain only in cycles where the display is idle.
// Optional build macro VMEM_ARB_VBLANK_ONLY_EN restricts writes to the vertical blank that follows a vsync falling edge.
module vmem_arbiter
  import vmem_arb_pkg::*;
#(
  parameter int H_W        = ARB_H_W,
  parameter int V_W        = ARB_V_W,
  parameter int DATA_W     = ARB_DATA_W,
  parameter int FIFO_DEPTH = ARB_FIFO_DEPTH
) (
  input  logic                         clk,
  input  logic                         resetn,
  input  logic                         disp_valid,
  input  logic [H_W-1:0]               disp_h_addr,
  input  logic [V_W-1:0]               disp_v_addr,
  input  logic                         vsync,
  input  logic                         wr_valid,
  output logic                         wr_ready,
  input  logic [H_W-1:0]               wr_h_addr,
  input  logic [V_W-1:0]               wr_v_addr,
  input  logic [DATA_W-1:0]            wr_data,
  input  logic                         flush,
  output logic [H_W+V_W-1:0]           mem_addr,
  output logic                         mem_we,
  output logic [DATA_W-1:0]            mem_wdata,
  output logic [$clog2(FIFO_DEPTH):0]  fifo_level,
  output logic [STALL_CNT_W-1:0]       stall_cnt
);

  localparam int ENT_W = H_W + V_W + DATA_W;

  logic [ENT_W-1:0] wr_entry;
  logic [ENT_W-1:0] head;
  logic             full;
  logic             empty;
  logic             push;
  logic             grant;
  logic             blank_ok;
  arb_state_e       state;

  assign wr_entry = {wr_h_addr, wr_v_addr, wr_data};
  assign wr_ready = !full;
  assign push     = wr_valid && !full && !flush;

  vmem_wr_fifo #(
    .WIDTH (ENT_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk    (clk),
    .resetn (resetn),
    .push   (push),
    .pop    (grant),
    .flush  (flush),
    .din    (wr_entry),
    .dout   (head),
    .full   (full),
    .empty  (empty),
    .level  (fifo_level)
  );

`ifdef VMEM_ARB_VBLANK_ONLY_EN
  logic vsync_q;
  logic vblank_ok;

  // Open the write window on a vsync falling edge; close it on the next active display read.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      vsync_q   <= 1'b1;
      vblank_ok <= 1'b0;
    end else begin
      vsync_q <= vsync;
      if (vsync_q && !vsync)
        vblank_ok <= 1'b1;
      else if (disp_valid)
        vblank_ok <= 1'b0;
    end
  end

  assign blank_ok = vblank_ok;
`else
  logic unused_vsync;
  assign unused_vsync = vsync;
  assign blank_ok     = 1'b1;
`endif

  assign grant     = !disp_valid && !empty && !flush && blank_ok;
  assign mem_we    = grant;
  assign mem_addr  = disp_valid ? {disp_h_addr, disp_v_addr} : head[ENT_W-1:DATA_W];
  assign mem_wdata = head[DATA_W-1:0];

  // Classify the current cycle: nothing buffered, writing, or waiting on the display.
  always_comb begin
    state = IDLE;
    if (grant)
      state = WRITE;
    else if (!empty)
      state = PEND;
  end

  // Saturating count of cycles where buffered data could not be written.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn)
      stall_cnt <= '0;
    else if (state == PEND && stall_cnt != '1)
      stall_cnt <= stall_cnt + 1'b1;
  end

endmodule

// File: tb/tb_vmem_arbiter.sv
// Directed bench for vmem_arbiter: table of per-cycle vectors plus hand-written reset and vblank sequences.
module tb_vmem_arbiter;
  import vmem_arb_pkg::*;

  logic        clk;
  logic        resetn;
  logic        disp_valid;
  logic [9:0]  disp_h_addr;
  logic [8:0]  disp_v_addr;
  logic        vsync;
  logic        wr_valid;
  logic        wr_ready;
  logic [9:0]  wr_h_addr;
  logic [8:0]  wr_v_addr;
  logic [23:0] wr_data;
  logic        flush;
  logic [18:0] mem_addr;
  logic        mem_we;
  logic [23:0] mem_wdata;
  logic [2:0]  fifo_level;
  logic [15:0] stall_cnt;

  int testsRun;
  int testsFailed;

  vmem_arbiter dut (
    .clk         (clk),
    .resetn      (resetn),
    .disp_valid  (disp_valid),
    .disp_h_addr (disp_h_addr),
    .disp_v_addr (disp_v_addr),
    .vsync       (vsync),
    .wr_valid    (wr_valid),
    .wr_ready    (wr_ready),
    .wr_h_addr   (wr_h_addr),
    .wr_v_addr   (wr_v_addr),
    .wr_data     (wr_data),
    .flush       (flush),
    .mem_addr    (mem_addr),
    .mem_we      (mem_we),
    .mem_wdata   (mem_wdata),
    .fifo_level  (fifo_level),
    .stall_cnt   (stall_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        dv;
    logic [9:0]  dh;
    logic [8:0]  dvv;
    logic        wv;
    wr_entry_t   wr;
    logic        fl;
    logic        eReady;
    logic        eWe;
    logic        chkAddr;
    logic [18:0] eAddr;
    logic [23:0] eData;
    logic [2:0]  eLevel;
    logic        chkStall;
    logic [15:0] eStall;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(
    input logic dv, input logic [9:0] dh, input logic [8:0] dvv,
    input logic wv, input logic [9:0] wh, input logic [8:0] wvv, input logic [23:0] wd,
    input logic fl, input logic er, input logic ewe,
    input logic ca, input logic [9:0] eh, input logic [8:0] ev, input logic [23:0] ed,
    input logic [2:0] el, input logic cs, input logic [15:0] es);
    vec_t r;
    r.dv = dv; r.dh = dh; r.dvv = dvv;
    r.wv = wv; r.wr.h = wh; r.wr.v = wvv; r.wr.data = wd;
    r.fl = fl; r.eReady = er; r.eWe = ewe;
    r.chkAddr = ca; r.eAddr = {eh, ev}; r.eData = ed;
    r.eLevel = el; r.chkStall = cs; r.eStall = es;
    return r;
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    testsRun++;
    if (act !== exp) begin
      testsFailed++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic applyStimulus(input logic dv, input logic [9:0] dh, input logic [8:0] dvv,
                               input logic wv, input wr_entry_t wr, input logic fl, input logic vs);
    @(posedge clk);
    #2;
    disp_valid  = dv;
    disp_h_addr = dh;
    disp_v_addr = dvv;
    wr_valid    = wv;
    wr_h_addr   = wr.h;
    wr_v_addr   = wr.v;
    wr_data     = wr.data;
    flush       = fl;
    vsync       = vs;
    #2;
  endtask

  task automatic doReset();
    resetn = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    resetn = 1'b1;
  endtask

  wr_entry_t noWr;
  wr_entry_t e;

  initial begin
    testsRun    = 0;
    testsFailed = 0;
    noWr        = '0;
    resetn      = 1'b0;
    disp_valid  = 1'b0;
    disp_h_addr = '0;
    disp_v_addr = '0;
    vsync       = 1'b1;
    wr_valid    = 1'b0;
    wr_h_addr   = '0;
    wr_v_addr   = '0;
    wr_data     = '0;
    flush       = 1'b0;
    doReset();

`ifndef VMEM_ARB_VBLANK_ONLY_EN
    // blanking write
    vecs.push_back(mk(0,0,0,     0,0,0,0,            0, 1,0, 0,0,0,0,            0, 1,0));
    vecs.push_back(mk(0,0,0,     1,5,7,24'hFF0000,   0, 1,0, 0,0,0,0,            0, 1,0));
    vecs.push_back(mk(0,0,0,     0,0,0,0,            0, 1,1, 1,5,7,24'hFF0000,   1, 1,0));
    vecs.push_back(mk(0,0,0,     0,0,0,0,            0, 1,0, 0,0,0,0,            0, 1,0));
    // display priority, buffer fills
    vecs.push_back(mk(1,100,50,  1,1,1,24'h111111,   0, 1,0, 1,100,50,0,         0, 1,0));
    vecs.push_back(mk(1,100,50,  1,2,2,24'h222222,   0, 1,0, 1,100,50,0,         1, 1,0));
    vecs.push_back(mk(1,101,51,  1,3,3,24'h333333,   0, 1,0, 1,101,51,0,         2, 1,1));
    vecs.push_back(mk(1,102,52,  1,4,4,24'h444444,   0, 1,0, 1,102,52,0,         3, 1,2));
    vecs.push_back(mk(1,103,53,  1,9,9,24'h999999,   0, 0,0, 1,103,53,0,         4, 1,3));
    vecs.push_back(mk(1,104,54,  0,0,0,0,            0, 0,0, 1,104,54,0,         4, 1,4));
    vecs.push_back(mk(1,105,55,  0,0,0,0,            0, 0,0, 1,105,55,0,         4, 1,5));
    // drain in order
    vecs.push_back(mk(0,0,0,     0,0,0,0,            0, 0,1, 1,1,1,24'h111111,   4, 1,6));
    vecs.push_back(mk(0,0,0,     0,0,0,0,            0, 1,1, 1,2,2,24'h222222,   3, 1,6));
    vecs.push_back(mk(0,0,0,     0,0,0,0,            0, 1,1, 1,3,3,24'h333333,   2, 1,6));
    vecs.push_back(mk(0,0,0,     0,0,0,0,            0, 1,1, 1,4,4,24'h444444,   1, 1,6));
    vecs.push_back(mk(0,0,0,     0,0,0,0,            0, 1,0, 0,0,0,0,            0, 1,6));
    // fill, then simultaneous push and pop
    vecs.push_back(mk(1,200,100, 1,10,20,24'hA00001, 0, 1,0, 1,200,100,0,        0, 1,6));
    vecs.push_back(mk(1,200,100, 1,11,21,24'hA00002, 0, 1,0, 1,200,100,0,        1, 1,6));
    vecs.push_back(mk(1,200,100, 1,12,22,24'hA00003, 0, 1,0, 1,200,100,0,        2, 1,7));
    vecs.push_back(mk(1,200,100, 1,13,23,24'hA00004, 0, 1,0, 1,200,100,0,        3, 1,8));
    vecs.push_back(mk(0,0,0,     1,30,40,24'hB00001, 0, 0,1, 1,10,20,24'hA00001, 4, 1,9));
    vecs.push_back(mk(0,0,0,     1,30,40,24'hB00001, 0, 1,1, 1,11,21,24'hA00002, 3, 1,9));
    vecs.push_back(mk(0,0,0,     1,31,41,24'hB00002, 0, 1,1, 1,12,22,24'hA00003, 3, 1,9));
    vecs.push_back(mk(0,0,0,     1,32,42,24'hB00003, 0, 1,1, 1,13,23,24'hA00004, 3, 1,9));
    vecs.push_back(mk(0,0,0,     0,0,0,0,            0, 1,1, 1,30,40,24'hB00001, 3, 1,9));
    vecs.push_back(mk(0,0,0,     0,0,0,0,            0, 1,1, 1,31,41,24'hB00002, 2, 1,9));
    vecs.push_back(mk(0,0,0,     0,0,0,0,            0, 1,1, 1,32,42,24'hB00003, 1, 1,9));
    vecs.push_back(mk(0,0,0,     0,0,0,0,            0, 1,0, 0,0,0,0,            0, 1,9));
    // flush with pending data and a simultaneous push
    vecs.push_back(mk(1,300,200, 1,50,60,24'hC00001, 0, 1,0, 1,300,200,0,        0, 1,9));
    vecs.push_back(mk(1,300,200, 1,51,61,24'hC00002, 0, 1,0, 1,300,200,0,        1, 1,9));
    vecs.push_back(mk(0,0,0,     1,52,62,24'hC00003, 1, 1,0, 0,0,0,0,            2, 1,10));
    vecs.push_back(mk(0,0,0,     0,0,0,0,            0, 1,0, 0,0,0,0,            0, 0,0));
    vecs.push_back(mk(0,0,0,     0,0,0,0,            0, 1,0, 0,0,0,0,            0, 0,0));

    foreach (vecs[i]) begin
      applyStimulus(vecs[i].dv, vecs[i].dh, vecs[i].dvv, vecs[i].wv, vecs[i].wr, vecs[i].fl, 1'b1);
      checkOutput($sformatf("v%0d.wr_ready", i), 32'(wr_ready), 32'(vecs[i].eReady));
      checkOutput($sformatf("v%0d.mem_we", i), 32'(mem_we), 32'(vecs[i].eWe));
      checkOutput($sformatf("v%0d.level", i), 32'(fifo_level), 32'(vecs[i].eLevel));
      if (vecs[i].chkAddr)
        checkOutput($sformatf("v%0d.mem_addr", i), 32'(mem_addr), 32'(vecs[i].eAddr));
      if (vecs[i].eWe)
        checkOutput($sformatf("v%0d.mem_wdata", i), 32'(mem_wdata), 32'(vecs[i].eData));
      if (vecs[i].chkStall)
        checkOutput($sformatf("v%0d.stall", i), 32'(stall_cnt), 32'(vecs[i].eStall));
    end
`else
    // write buffered in an h-blank gap must wait for vsync to fall
    e.h = 10'd5; e.v = 9'd7; e.data = 24'hFF0000;
    applyStimulus(0, 0, 0, 1, e, 0, 1);
    checkOutput("vb.push_we", 32'(mem_we), 32'd0);
    applyStimulus(0, 0, 0, 0, noWr, 0, 1);
    checkOutput("vb.hgap_we", 32'(mem_we), 32'd0);
    checkOutput("vb.hgap_level", 32'(fifo_level), 32'd1);
    applyStimulus(1, 10'd20, 9'd30, 0, noWr, 0, 1);
    checkOutput("vb.disp_we", 32'(mem_we), 32'd0);
    checkOutput("vb.disp_addr", 32'(mem_addr), 32'({10'd20, 9'd30}));
    applyStimulus(0, 0, 0, 0, noWr, 0, 1);
    checkOutput("vb.hgap2_we", 32'(mem_we), 32'd0);
    applyStimulus(0, 0, 0, 0, noWr, 0, 0);
    checkOutput("vb.fall_we", 32'(mem_we), 32'd0);
    applyStimulus(0, 0, 0, 0, noWr, 0, 0);
    checkOutput("vb.window_we", 32'(mem_we), 32'd1);
    checkOutput("vb.window_addr", 32'(mem_addr), 32'({10'd5, 9'd7}));
    checkOutput("vb.window_data", 32'(mem_wdata), 32'hFF0000);
    e.h = 10'd8; e.v = 9'd9; e.data = 24'h00FF00;
    applyStimulus(0, 0, 0, 1, e, 0, 0);
    checkOutput("vb.drained_level", 32'(fifo_level), 32'd0);
    applyStimulus(1, 0, 0, 0, noWr, 0, 1);
    checkOutput("vb.close_we", 32'(mem_we), 32'd0);
    applyStimulus(0, 0, 0, 0, noWr, 0, 1);
    checkOutput("vb.closed_we", 32'(mem_we), 32'd0);
    checkOutput("vb.closed_level", 32'(fifo_level), 32'd1);
`endif

    // reset in the middle of operation with three entries buffered
    doReset();
    e.h = 10'd1; e.v = 9'd2; e.data = 24'h123456;
    applyStimulus(1, 0, 0, 1, e, 0, 1);
    applyStimulus(1, 0, 0, 1, e, 0, 1);
    applyStimulus(1, 0, 0, 1, e, 0, 1);
    applyStimulus(1, 0, 0, 0, noWr, 0, 1);
    checkOutput("rst.pre_level", 32'(fifo_level), 32'd3);
    checkOutput("rst.pre_stall", 32'(stall_cnt), 32'd2);
    @(posedge clk);
    #2;
    disp_valid = 1'b0;
    #1;
    resetn = 1'b0;
    #1;
    checkOutput("rst.level", 32'(fifo_level), 32'd0);
    checkOutput("rst.mem_we", 32'(mem_we), 32'd0);
    checkOutput("rst.stall", 32'(stall_cnt), 32'd0);
    checkOutput("rst.wr_ready", 32'(wr_ready), 32'd1);
    @(negedge clk);
    resetn = 1'b1;
    repeat (2) @(posedge clk);

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
